stopwatch_core: RTL and testbench

Upstream timing stage for the 4-digit seven-segment driver. Generates a 1 Hz-class tick from the system clock and runs an MM:SS stopwatch with start/stop, clear and lap-freeze controls. Outputs packed BCD minutes/seconds: tens in [6:4], ones in [3:0]. These feed the display's stopwatch_min/stopwatch_sec inputs directly.

---
 rtl/stopwatch_core.sv | 161 ++++++++++++++++
 tb/tb_stopwatch_core.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_core.sv
// MM:SS BCD stopwatch with start/stop, clear and lap freeze, paced by a clk prescaler.
// Buttons are synchronized and edge-detected; each action lands two edges after the raw rise.
module stopwatch_core #(
  parameter int TICK_DIV    = 100000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [6:0] stopwatch_sec,
  output logic [6:0] stopwatch_min,
  output logic       running,
  output logic       lap_active,
  output logic       rollover
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;

  // Button bus order: {lap, clear, start_stop}
  logic [2:0] sync_q [SYNC_STAGES];
  logic [2:0] prev_q;
  logic [2:0] btn_edge;
  logic       ev_ss;
  logic       ev_clr;
  logic       ev_lap;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= {lap, clear, start_stop};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign btn_edge = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign ev_ss    = btn_edge[0];
  assign ev_clr   = btn_edge[1];
  assign ev_lap   = btn_edge[2];

  // Returns {carry, next} for a packed BCD 00-59 value
  function automatic logic [7:0] bcd_inc(input logic [6:0] v);
    if (v[3:0] == 4'd9) begin
      if (v[6:4] == 3'd5) return {1'b1, 7'h00};
      return {1'b0, v[6:4] + 3'd1, 4'd0};
    end
    return {1'b0, v[6:4], v[3:0] + 4'd1};
  endfunction

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [6:0]    sec_q, sec_d, min_q, min_d;
  logic [6:0]    lat_sec_q, lat_sec_d, lat_min_q, lat_min_d;
  logic          lap_q, lap_d;
  logic          roll_d;
  logic          tick;
  logic [7:0]    sec_inc, min_inc;

  assign tick    = (state_q == S_RUN) && (pre_q == PRE_MAX);
  assign sec_inc = bcd_inc(sec_q);
  assign min_inc = bcd_inc(min_q);

  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    sec_d     = sec_q;
    min_d     = min_q;
    lat_sec_d = lat_sec_q;
    lat_min_d = lat_min_q;
    lap_d     = lap_q;
    roll_d    = 1'b0;

    if (state_q == S_RUN) begin
      pre_d = tick ? '0 : pre_q + 1'b1;
      if (tick) begin
        sec_d = sec_inc[6:0];
        if (sec_inc[7]) begin
          min_d  = min_inc[6:0];
          roll_d = min_inc[7];
        end
      end
    end

    // Lap latches the pre-increment count even when a tick lands the same cycle
    if (ev_lap && state_q != S_IDLE) begin
      if (!lap_q) begin
        lat_sec_d = sec_q;
        lat_min_d = min_q;
        lap_d     = 1'b1;
      end else begin
        lap_d = 1'b0;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (ev_ss) begin
          state_d = S_RUN;
          pre_d   = '0;
        end
      end
      S_RUN: begin
        if (ev_ss) state_d = S_PAUSE;
      end
      S_PAUSE: begin
        // Clear wins over a same-cycle start_stop and over lap
        if (ev_clr) begin
          state_d   = S_IDLE;
          pre_d     = '0;
          sec_d     = '0;
          min_d     = '0;
          lat_sec_d = '0;
          lat_min_d = '0;
          lap_d     = 1'b0;
        end else if (ev_ss) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      pre_q         <= '0;
      sec_q         <= '0;
      min_q         <= '0;
      lat_sec_q     <= '0;
      lat_min_q     <= '0;
      lap_q         <= 1'b0;
      stopwatch_sec <= '0;
      stopwatch_min <= '0;
      rollover      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pre_q         <= pre_d;
      sec_q         <= sec_d;
      min_q         <= min_d;
      lat_sec_q     <= lat_sec_d;
      lat_min_q     <= lat_min_d;
      lap_q         <= lap_d;
      stopwatch_sec <= lap_d ? lat_sec_d : sec_d;
      stopwatch_min <= lap_d ? lat_min_d : min_d;
      rollover      <= roll_d;
    end
  end

  assign running    = (state_q == S_RUN);
  assign lap_active = lap_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core with TICK_DIV=4: one stopwatch second every four clocks.
// Expected snapshots {min, sec, running, lap_active, rollover} are queued then checked in order.
module tb_stopwatch_core;

  logic       clk;
  logic       reset_n;
  logic       start_stop;
  logic       clear;
  logic       lap;
  logic [6:0] stopwatch_sec;
  logic [6:0] stopwatch_min;
  logic       running;
  logic       lap_active;
  logic       rollover;

  stopwatch_core #(.TICK_DIV(4), .SYNC_STAGES(2)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start_stop    (start_stop),
    .clear         (clear),
    .lap           (lap),
    .stopwatch_sec (stopwatch_sec),
    .stopwatch_min (stopwatch_min),
    .running       (running),
    .lap_active    (lap_active),
    .rollover      (rollover)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [16:0] v;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  logic [16:0] obs;
  assign obs = {stopwatch_min, stopwatch_sec, running, lap_active, rollover};

  function automatic logic [16:0] pk(input logic [6:0] m, input logic [6:0] s,
                                     input logic r, input logic l, input logic o);
    return {m, s, r, l, o};
  endfunction

  // Mask {lap, clear, start_stop}; returns 1ns after the edge where the action takes effect,
  // which is three edges after the current one.
  task automatic press(input logic [2:0] m);
    @(negedge clk);
    {lap, clear, start_stop} = m;
    @(posedge clk);
    @(negedge clk);
    {lap, clear, start_stop} = 3'b000;
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    exp_t e;
    reset_n = 1'b0;
    {lap, clear, start_stop} = 3'b000;
    sb.push_back('{"rst_state", pk(7'h00, 7'h00, 0, 0, 0)});
    repeat (3) @(posedge clk);
    #1;
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
    @(negedge clk);
    reset_n = 1'b1;
    press(3'b001);
    sb.push_back('{"rst_pre_1234", pk(7'h12, 7'h34, 1, 0, 0)});
    sb.push_back('{"rst_async", pk(7'h00, 7'h00, 0, 0, 0)});
    sb.push_back('{"rst_release_idle", pk(7'h00, 7'h00, 0, 0, 0)});
    repeat (3016) @(posedge clk);
    #1;
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
    #1 reset_n = 1'b0;
    #1;
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
  endtask

  task automatic test_counting;
    exp_t e;
    press(3'b001);
    sb.push_back('{"cnt_start", pk(7'h00, 7'h00, 1, 0, 0)});
    sb.push_back('{"cnt_0010", pk(7'h00, 7'h10, 1, 0, 0)});
    sb.push_back('{"cnt_0059", pk(7'h00, 7'h59, 1, 0, 0)});
    sb.push_back('{"cnt_0100", pk(7'h01, 7'h00, 1, 0, 0)});
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
    repeat (40) @(posedge clk);
    #1;
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
    repeat (196) @(posedge clk);
    #1;
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
    repeat (4) @(posedge clk);
    #1;
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
    press(3'b001);
    press(3'b010);
    sb.push_back('{"cnt_cleared", pk(7'h00, 7'h00, 0, 0, 0)});
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
  endtask

  task automatic test_pause_resume;
    exp_t e;
    press(3'b001);
    repeat (19) @(posedge clk);
    #1;
    press(3'b001);
    sb.push_back('{"pr_paused", pk(7'h00, 7'h05, 0, 0, 0)});
    sb.push_back('{"pr_held", pk(7'h00, 7'h05, 0, 0, 0)});
    sb.push_back('{"pr_resumed", pk(7'h00, 7'h05, 1, 0, 0)});
    sb.push_back('{"pr_one_clk", pk(7'h00, 7'h05, 1, 0, 0)});
    sb.push_back('{"pr_two_clk", pk(7'h00, 7'h06, 1, 0, 0)});
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
    repeat (50) @(posedge clk);
    #1;
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
    press(3'b001);
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      e = sb.pop_front(); total++;
      if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
    end
    press(3'b001);
    press(3'b010);
  endtask

  task automatic test_lap;
    exp_t e;
    press(3'b001);
    repeat (11) @(posedge clk);
    #1;
    press(3'b100);
    sb.push_back('{"lap_freeze", pk(7'h00, 7'h03, 1, 1, 0)});
    sb.push_back('{"lap_frozen_8_ticks", pk(7'h00, 7'h03, 1, 1, 0)});
    sb.push_back('{"lap_release", pk(7'h00, 7'h11, 1, 0, 0)});
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
    repeat (30) @(posedge clk);
    #1;
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
    press(3'b100);
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
  endtask

  task automatic test_clear_rules;
    exp_t e;
    // Still running from the lap scenario at 00:11
    press(3'b010);
    sb.push_back('{"clr_in_run_ignored", pk(7'h00, 7'h12, 1, 0, 0)});
    sb.push_back('{"clr_pause", pk(7'h00, 7'h13, 0, 0, 0)});
    sb.push_back('{"clr_from_pause", pk(7'h00, 7'h00, 0, 0, 0)});
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
    press(3'b001);
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
    press(3'b010);
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
    press(3'b001);
    repeat (33) @(posedge clk);
    #1;
    // Pause lands on a tick edge: the tick still counts
    press(3'b001);
    sb.push_back('{"clr_pause_on_tick", pk(7'h00, 7'h09, 0, 0, 0)});
    sb.push_back('{"clr_and_ss", pk(7'h00, 7'h00, 0, 0, 0)});
    sb.push_back('{"clr_ss_dropped", pk(7'h00, 7'h00, 0, 0, 0)});
    sb.push_back('{"clr_in_idle", pk(7'h00, 7'h00, 0, 0, 0)});
    sb.push_back('{"lap_in_idle", pk(7'h00, 7'h00, 0, 0, 0)});
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
    press(3'b011);
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
    repeat (12) @(posedge clk);
    #1;
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
    press(3'b010);
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
    press(3'b100);
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
  endtask

  task automatic test_rollover;
    exp_t e;
    press(3'b001);
    sb.push_back('{"ro_5958", pk(7'h59, 7'h58, 1, 0, 0)});
    sb.push_back('{"ro_5959", pk(7'h59, 7'h59, 1, 0, 0)});
    sb.push_back('{"ro_wrap", pk(7'h00, 7'h00, 1, 0, 1)});
    sb.push_back('{"ro_pulse_end", pk(7'h00, 7'h00, 1, 0, 0)});
    sb.push_back('{"ro_pause_on_tick", pk(7'h00, 7'h01, 0, 0, 0)});
    repeat (14392) @(posedge clk);
    #1;
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
    repeat (4) @(posedge clk);
    #1;
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
    repeat (4) @(posedge clk);
    #1;
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
    @(posedge clk);
    #1;
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
    press(3'b001);
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
  endtask

  initial begin
    reset_n    = 1'b0;
    start_stop = 1'b0;
    clear      = 1'b0;
    lap        = 1'b0;
    test_reset();
    test_counting();
    test_pause_resume();
    test_lap();
    test_clear_rules();
    test_rollover();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
